// File: rtl/adc_trace_pkg.sv
// Shared types and constants for the triggered multi-channel
// ADC trace renderer.
package adc_trace_pkg;

    typedef enum logic [1:0] {
        SYNC,
        ARM,
        CAPT,
        DRAW
    } state_t;

    typedef enum logic [1:0] {
        M_AUTO,
        M_NORMAL,
        M_SINGLE,
        M_STOP
    } trig_mode_t;

    // Per-pixel sub-steps of the raster scan
    typedef enum logic [1:0] {
        P_RD,
        P_PIX,
        P_REQ,
        P_WAIT
    } phase_t;

    localparam logic [15:0] CLR [0:3] = '{
        16'h667f,
        16'hffe0,
        16'h07e0,
        16'hf81f
    };

    localparam logic [15:0] GRID = 16'h2104;

    localparam logic [23:0] FB_OFS = 24'h080000;

    // Word address of the buffer selected for drawing
    function automatic logic [23:0] fb_base(
        input logic [23:0] base,
        input logic        sel
    );
        return base + (sel ? 24'h000000 : FB_OFS);
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace memory: one write port, one registered
// read port, single clock, maps onto block RAM.
module trace_ram #(
    parameter int DEPTH = 800,
    parameter int WIDTH = 20,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write when enabled; read data appears one cycle after raddr
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/adc_trace_render.sv
// Triggered multi-channel trace capture and rasteriser into a
// double-buffered framebuffer via the shared memory request port.
module adc_trace_render
    import adc_trace_pkg::*;
#(
    parameter logic [23:0] BASE     = 24'h000000,
    parameter int          W        = 800,
    parameter int          H        = 480,
    parameter int          CH       = 2,
    parameter int          DW       = 10,
    parameter int          AUTO_TMO = 4096
) (
    input  logic           clkSYS,
    input  logic           n_reset,
    input  logic           smp_valid,
    input  logic [CH*DW-1:0] smp,
    input  logic [1:0]     trig_ch,
    input  logic [DW-1:0]  trig_level,
    input  logic           trig_fall,
    input  logic [1:0]     trig_mode,
    input  logic           arm,
    output logic           triggered,
    output logic           swap,
    input  logic           stat,
    output logic [23:0]    addr,
    output logic [15:0]    data,
    output logic           req,
    output logic           wr,
    input  logic           ack
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int RW = (H > 1) ? $clog2(H) : 1;
    localparam int TW = $clog2(AUTO_TMO + 1);
    localparam int PW = DW + 10;

    state_t     state;
    phase_t     phase;
    trig_mode_t cur_mode;
    trig_mode_t mode_in;

    logic            arm_seen;
    logic            have_prev;
    logic [DW-1:0]   prev;
    logic [TW-1:0]   tmo;
    logic [CW-1:0]   wptr;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [5:0]      gcol;
    logic [5:0]      grow;
    logic [23:0]     pix_ofs;

    logic [1:0]      tsel;
    logic [DW-1:0]   cur;
    logic            hit;
    logic            fire;
    logic            ram_we;
    logic [CW-1:0]   ram_wa;
    logic [CH*DW-1:0] ram_q;
    logic [15:0]     pix;
    logic            sync_go;
    logic            last_col;
    logic            last_row;

    assign wr      = 1'b1;
    assign mode_in = trig_mode_t'(trig_mode);

    trace_ram #(
        .DEPTH (W),
        .WIDTH (CH * DW),
        .AW    (CW)
    ) u_ram (
        .clk   (clkSYS),
        .we    (ram_we),
        .waddr (ram_wa),
        .wdata (smp),
        .raddr (col),
        .rdata (ram_q)
    );

    // Trigger channel select and edge detection on the live sample
    always_comb begin
        tsel = (int'(trig_ch) < CH) ? trig_ch : 2'd0;
        cur  = smp[int'(tsel)*DW +: DW];
        if (trig_fall) begin
            hit = (prev > trig_level) && (cur <= trig_level);
        end else begin
            hit = (prev < trig_level) && (cur >= trig_level);
        end
        fire = smp_valid && (state == ARM) &&
               ((have_prev && hit) ||
                ((cur_mode == M_AUTO) &&
                 (tmo == TW'(AUTO_TMO - 1))));
    end

    // Trace RAM write: trigger sample at entry 0, then one per strobe
    always_comb begin
        ram_we = fire || (smp_valid && (state == CAPT));
        ram_wa = (state == ARM) ? '0 : wptr;
    end

    // SYNC exit: display caught up, not stopped, single mode armed
    always_comb begin
        sync_go = (stat == swap) && (mode_in != M_STOP) &&
                  ((mode_in != M_SINGLE) || arm_seen || arm);
        last_col = (col == CW'(W - 1));
        last_row = (row == RW'(H - 1));
    end

    // Pixel colour: lowest channel on this row wins, else grid/black
    always_comb begin
        pix = ((gcol == 6'd0) || (grow == 6'd0)) ? GRID : 16'h0000;
        for (int c = CH - 1; c >= 0; c--) begin
            if ((PW'(H - 1) -
                 ((PW'(ram_q[c*DW +: DW]) * PW'(H)) >> DW))
                == PW'(row)) begin
                pix = CLR[2'(c)];
            end
        end
    end

    // Main controller: sync, arm, capture and raster handshake
    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            state     <= SYNC;
            phase     <= P_RD;
            cur_mode  <= M_AUTO;
            arm_seen  <= 1'b0;
            have_prev <= 1'b0;
            prev      <= '0;
            tmo       <= '0;
            wptr      <= '0;
            col       <= '0;
            row       <= '0;
            gcol      <= '0;
            grow      <= '0;
            pix_ofs   <= '0;
            req       <= 1'b0;
            triggered <= 1'b0;
            swap      <= 1'b0;
            data      <= '0;
            addr      <= BASE + FB_OFS;
        end else begin
            unique case (state)
                SYNC: begin
                    if (arm) begin
                        arm_seen <= 1'b1;
                    end
                    if (sync_go) begin
                        state     <= ARM;
                        cur_mode  <= mode_in;
                        arm_seen  <= 1'b0;
                        have_prev <= 1'b0;
                        tmo       <= '0;
                    end
                end
                ARM: begin
                    if (smp_valid) begin
                        prev      <= cur;
                        have_prev <= 1'b1;
                        tmo       <= tmo + 1'b1;
                        if (fire) begin
                            state     <= CAPT;
                            triggered <= 1'b1;
                            wptr      <= CW'(1);
                        end
                    end
                end
                CAPT: begin
                    if (smp_valid) begin
                        if (wptr == CW'(W - 1)) begin
                            wptr    <= '0;
                            state   <= DRAW;
                            phase   <= P_RD;
                            col     <= '0;
                            row     <= '0;
                            gcol    <= '0;
                            grow    <= '0;
                            pix_ofs <= '0;
                        end else begin
                            wptr <= wptr + 1'b1;
                        end
                    end
                end
                DRAW: begin
                    unique case (phase)
                        P_RD: begin
                            phase <= P_PIX;
                        end
                        P_PIX: begin
                            data  <= pix;
                            addr  <= fb_base(BASE, swap) + pix_ofs;
                            phase <= P_REQ;
                        end
                        P_REQ: begin
                            req   <= 1'b1;
                            phase <= P_WAIT;
                        end
                        P_WAIT: begin
                            if (ack) begin
                                req     <= 1'b0;
                                phase   <= P_RD;
                                pix_ofs <= pix_ofs + 1'b1;
                                if (last_col) begin
                                    col  <= '0;
                                    gcol <= '0;
                                    if (last_row) begin
                                        row       <= '0;
                                        grow      <= '0;
                                        swap      <= ~swap;
                                        triggered <= 1'b0;
                                        state     <= SYNC;
                                    end else begin
                                        row  <= row + 1'b1;
                                        grow <= (grow == 6'd39) ?
                                                6'd0 : grow + 1'b1;
                                    end
                                end else begin
                                    col  <= col + 1'b1;
                                    gcol <= (gcol == 6'd49) ?
                                            6'd0 : gcol + 1'b1;
                                end
                            end
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_trace_render.sv
// Bench for adc_trace_render: table of capture/render scenarios
// plus single-mode, stop-mode and reset sequences.
module tb_adc_trace_render;
    import adc_trace_pkg::*;

    localparam int W = 16;
    localparam int H = 4;
    localparam int CH = 2;
    localparam int DW = 10;
    localparam int AUTO_TMO = 8;
    localparam logic [23:0] BASE = 24'h000000;
    localparam logic [23:0] OFS = 24'h080000;
    localparam logic [15:0] COL [0:3] = '{
        16'h667f, 16'hffe0, 16'h07e0, 16'hf81f
    };
    localparam logic [15:0] GRIDC = 16'h2104;

    typedef struct {
        int mode;
        int level;
        int fall;
        int tch;
        int pat;
        int c0;
        int c1;
        int stall;
        int exp_idx;
    } vec_t;

    logic clkSYS = 1'b0;
    logic n_reset = 1'b0;
    logic smp_valid = 1'b0;
    logic [CH*DW-1:0] smp = '0;
    logic [1:0] trig_ch = 2'd0;
    logic [DW-1:0] trig_level = '0;
    logic trig_fall = 1'b0;
    logic [1:0] trig_mode = 2'd0;
    logic arm = 1'b0;
    logic triggered;
    logic swap;
    logic stat = 1'b0;
    logic [23:0] addr;
    logic [15:0] data;
    logic req;
    logic wr;
    logic ack = 1'b0;

    int checks = 0;
    int errors = 0;
    bit sw = 1'b0;
    int st [0:63][0:1];
    logic [15:0] exp_pix [0:W*H-1];

    always #5 clkSYS = ~clkSYS;

    adc_trace_render #(
        .BASE(BASE), .W(W), .H(H), .CH(CH), .DW(DW),
        .AUTO_TMO(AUTO_TMO)
    ) dut (
        .clkSYS(clkSYS), .n_reset(n_reset),
        .smp_valid(smp_valid), .smp(smp),
        .trig_ch(trig_ch), .trig_level(trig_level),
        .trig_fall(trig_fall), .trig_mode(trig_mode),
        .arm(arm), .triggered(triggered), .swap(swap),
        .stat(stat), .addr(addr), .data(data),
        .req(req), .wr(wr), .ack(ack)
    );

    task automatic chk(input string name, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int trace_row(input int s);
        return (H - 1) - (s * H) / 1024;
    endfunction

    function automatic void make_stream(input int pat, input int c0,
                                        input int c1, input int fall,
                                        input int tch);
        int c;
        c = (tch >= CH) ? 0 : tch;
        for (int k = 0; k < 64; k++) begin
            case (pat)
                0: begin
                    st[k][0] = (k * 100) % 1024;
                    st[k][1] = int'($urandom_range(0, 1023));
                end
                1: begin
                    st[k][0] = c0;
                    st[k][1] = c1;
                end
                default: begin
                    st[k][0] = int'($urandom_range(0, 1023));
                    st[k][1] = int'($urandom_range(0, 1023));
                end
            endcase
        end
        if (pat == 2) begin
            st[30][c] = fall ? 900 : 100;
            st[31][c] = fall ? 100 : 900;
        end
    endfunction

    function automatic int find_trig(input int mode, input int level,
                                     input int fall, input int tch);
        int c;
        c = (tch >= CH) ? 0 : tch;
        for (int i = 0; i < 64; i++) begin
            if (i > 0) begin
                if (fall == 0 && st[i-1][c] < level && st[i][c] >= level)
                    return i;
                if (fall != 0 && st[i-1][c] > level && st[i][c] <= level)
                    return i;
            end
            if (mode == 0 && i == AUTO_TMO - 1)
                return i;
        end
        return 0;
    endfunction

    function automatic void build_exp(input int idx);
        logic [15:0] p;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                p = (c % 50 == 0 || r % 40 == 0) ? GRIDC : 16'h0000;
                for (int k = CH - 1; k >= 0; k--) begin
                    if (trace_row(st[idx + c][k]) == r)
                        p = COL[k];
                end
                exp_pix[r * W + c] = p;
            end
        end
    endfunction

    task automatic send(input int n);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clkSYS);
            smp = {10'(st[k][1]), 10'(st[k][0])};
            smp_valid = 1'b1;
            @(negedge clkSYS);
            smp_valid = 1'b0;
        end
    endtask

    task automatic serve(input int n_px, input int stall_at,
                         input logic [23:0] base);
        logic [23:0] pa;
        logic [15:0] pd;
        int wn;
        bit stable;
        for (int i = 0; i < n_px; i++) begin
            wn = 0;
            pa = addr;
            pd = data;
            while (!req && wn < 300) begin
                pa = addr;
                pd = data;
                @(negedge clkSYS);
                wn++;
            end
            if (!req) begin
                chk("req_timeout", 0, 1);
                return;
            end
            chk("px_addr", addr, base + 24'(i));
            chk("px_data", data, exp_pix[i]);
            if (wn > 0) begin
                chk("setup_addr", pa, addr);
                chk("setup_data", pd, data);
            end
            if (i == 0) chk("trig_high", triggered, 1);
            if (i == stall_at) begin
                stable = 1'b1;
                pa = addr;
                pd = data;
                repeat (20) begin
                    @(negedge clkSYS);
                    if (!req || addr != pa || data != pd) stable = 1'b0;
                end
                chk("stall_hold", stable, 1);
            end
            repeat ($urandom_range(0, 2)) @(negedge clkSYS);
            ack = 1'b1;
            @(negedge clkSYS);
            ack = 1'b0;
            chk("req_drop", req, 0);
        end
    endtask

    task automatic do_frame(input vec_t v, input int n_px);
        int idx;
        trig_mode = 2'(v.mode);
        trig_level = 10'(v.level);
        trig_fall = 1'(v.fall);
        trig_ch = 2'(v.tch);
        stat = sw;
        make_stream(v.pat, v.c0, v.c1, v.fall, v.tch);
        idx = (v.exp_idx >= 0) ? v.exp_idx :
              find_trig(v.mode, v.level, v.fall, v.tch);
        build_exp(idx);
        repeat (3) @(negedge clkSYS);
        send(idx + W);
        serve(n_px, v.stall, sw ? BASE : BASE + OFS);
        if (n_px == W * H) begin
            sw = ~sw;
            chk("swap_toggle", swap, sw);
            chk("trig_clear", triggered, 0);
        end
    endtask

    task automatic expect_idle(input string name);
        make_stream(0, 0, 0, 0, 0);
        send(40);
        chk({name, "_trig"}, triggered, 0);
        chk({name, "_req"}, req, 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl [8];
        vec_t v2;
        int wn;
        tbl[0] = '{1, 512, 0, 0, 0, 0, 0, -1, 6};
        tbl[1] = '{0, 512, 0, 0, 1, 100, 100, -1, 7};
        tbl[2] = '{0, 512, 0, 0, 1, 1023, 1023, -1, 7};
        tbl[3] = '{0, 512, 0, 0, 1, 1023, 0, -1, 7};
        tbl[4] = '{1, 512, 1, 1, 2, 0, 0, -1, -1};
        tbl[5] = '{1, 300, 0, 3, 2, 0, 0, -1, -1};
        tbl[6] = '{1, 512, 0, 0, 0, 0, 0, 25, 6};
        tbl[7] = '{1, 700, 0, 1, 2, 0, 0, -1, -1};
        v2 = '{2, 512, 0, 0, 0, 0, 0, -1, 6};

        repeat (2) @(negedge clkSYS);
        chk("rst_req", req, 0);
        chk("rst_trig", triggered, 0);
        chk("rst_swap", swap, 0);
        chk("rst_data", data, 0);
        chk("rst_addr", addr, BASE + OFS);
        chk("wr_const", wr, 1);
        n_reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_frame(tbl[i], W * H);
        end

        trig_mode = 2'd2;
        stat = ~sw;
        repeat (3) @(negedge clkSYS);
        arm = 1'b1;
        @(negedge clkSYS);
        arm = 1'b0;
        expect_idle("single_stat_wait");
        do_frame(v2, W * H);

        stat = sw;
        trig_mode = 2'd3;
        repeat (3) @(negedge clkSYS);
        expect_idle("stop_hold");
        trig_mode = 2'd2;
        repeat (3) @(negedge clkSYS);
        expect_idle("single_no_arm");
        arm = 1'b1;
        @(negedge clkSYS);
        arm = 1'b0;
        do_frame(v2, 10);

        wn = 0;
        while (!req && wn < 50) begin
            @(negedge clkSYS);
            wn++;
        end
        chk("pre_reset_req", req, 1);
        chk("pre_reset_swap", swap, 1);
        #2;
        n_reset = 1'b0;
        #1;
        chk("async_req", req, 0);
        chk("async_swap", swap, 0);
        chk("async_trig", triggered, 0);
        chk("async_addr", addr, BASE + OFS);
        @(negedge clkSYS);
        n_reset = 1'b1;
        sw = 1'b0;
        trig_mode = 2'd1;
        stat = 1'b1;
        repeat (3) @(negedge clkSYS);
        chk("sync_after_reset", dut.state, SYNC);
        do_frame(tbl[0], W * H);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
